// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider, one quotient bit per clock.
// Unsigned N-bit quotient and remainder after N RUN cycles; a zero divisor
// returns all-ones / dividend with the dbz flag set, without entering RUN.
module seq_divider #(
  parameter int unsigned N = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quot,
  output logic [N-1:0] rem,
  output logic         dbz
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   qa_q, qa_d;       // dividend shifting out, quotient shifting in
  logic [N-1:0]   r_q, r_d;         // partial remainder; bit N lives only in t_c
  logic [N-1:0]   b_q, b_d;         // captured divisor
  logic [CW-1:0]  cnt_q, cnt_d;     // iterations left
  logic           zpend_q, zpend_d; // zero-divisor result due on the next edge
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [N-1:0]   quot_q, quot_d;
  logic [N-1:0]   rem_q, rem_d;
  logic           dbz_q, dbz_d;

  logic [N:0]     t_c;
  logic           ge_c;
  logic [N-1:0]   r_sub_c;
  logic [N-1:0]   r_nx_c;
  logic [N-1:0]   qa_nx_c;

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
  always_comb begin
    t_c     = {r_q, qa_q[N-1]};
    ge_c    = (t_c >= {1'b0, b_q});
    // When t >= b the difference is below b, so the low N bits are exact.
    r_sub_c = N'(t_c[N-1:0] - b_q);
    if (ge_c) begin
      r_nx_c  = r_sub_c;
      qa_nx_c = {qa_q[N-2:0], 1'b1};
    end else begin
      r_nx_c  = t_c[N-1:0];
      qa_nx_c = {qa_q[N-2:0], 1'b0};
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    qa_d    = qa_q;
    r_d     = r_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    zpend_d = 1'b0;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    // Retire a zero-divisor request captured on the previous edge.
    if (zpend_q) begin
      quot_d = '1;
      rem_d  = qa_q;
      dbz_d  = 1'b1;
      done_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          qa_d = a;
          if (b != '0) begin
            b_d     = b;
            r_d     = '0;
            cnt_d   = CW'(N);
            state_d = S_RUN;
          end else begin
            zpend_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        qa_d  = qa_nx_c;
        r_d   = r_nx_c;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quot_d  = qa_nx_c;
          rem_d   = r_nx_c;
          dbz_d   = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      qa_q    <= '0;
      r_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      zpend_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      qa_q    <= qa_d;
      r_q     <= r_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      zpend_q <= zpend_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign quot = quot_q;
  assign rem  = rem_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed literal cases, pattern sweeps and random
// operands, with a per-cycle comparison against a scheduling model built on / and %.
module tb_seq_divider;

  localparam int unsigned N  = 65;
  localparam int unsigned W2 = 2 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] quot;
  logic [N-1:0] rem;
  logic         dbz;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  seq_divider #(.N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .quot (quot),
    .rem  (rem),
    .dbz  (dbz)
  );

  task automatic check(input string name, input logic [W2-1:0] got, input logic [W2-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Reference model: results are scheduled by edge number, values from / and %.
  typedef struct {
    int           due;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         z;
  } res_t;

  res_t         pend[$];
  res_t         r_new;
  res_t         r_old;
  int           cyc     = 0;
  int           run_end = 0;
  logic         m_busy  = 1'b0;
  logic         m_done  = 1'b0;
  logic         m_dbz   = 1'b0;
  logic [N-1:0] m_quot  = '0;
  logic [N-1:0] m_rem   = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend.delete();
      run_end = 0;
      m_busy  = 1'b0;
      m_done  = 1'b0;
      m_dbz   = 1'b0;
      m_quot  = '0;
      m_rem   = '0;
    end else begin
      cyc++;
      m_done = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        r_old  = pend.pop_front();
        m_quot = r_old.q;
        m_rem  = r_old.r;
        m_dbz  = r_old.z;
        m_done = 1'b1;
      end
      // Divider is idle before this edge once the previous run has retired.
      if (start && cyc > run_end) begin
        if (b == '0) begin
          r_new.due = cyc + 1;
          r_new.q   = '1;
          r_new.r   = a;
          r_new.z   = 1'b1;
        end else begin
          run_end   = cyc + int'(N);
          r_new.due = run_end;
          r_new.q   = a / b;
          r_new.r   = a % b;
          r_new.z   = 1'b0;
        end
        pend.push_back(r_new);
      end
      m_busy = (cyc < run_end);
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      check("cyc_busy", W2'(busy), W2'(m_busy));
      check("cyc_done", W2'(done), W2'(m_done));
      check("cyc_dbz",  W2'(dbz),  W2'(m_dbz));
      check("cyc_quot", W2'(quot), W2'(m_quot));
      check("cyc_rem",  W2'(rem),  W2'(m_rem));
    end
  end

  // Issue one operation from the low clock phase and check its result.
  // Returns at the falling edge of the done cycle so a chained start lands there.
  task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_b,
                        input logic [N-1:0] eq, input logic [N-1:0] er,
                        input logic ez, input int exp_lat, input bit poke);
    int           lat;
    int           busy_cnt;
    bit           seen;
    logic [W2-1:0] recon;
    a     = ta;
    b     = tb_b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    for (int i = 0; i < int'(N) + 8; i++) begin
      @(negedge clk);
      if (poke) begin
        if (lat == 9) begin
          start = 1'b1;
          a     = 1;
          b     = 1;
        end else begin
          start = 1'b0;
        end
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      @(posedge clk);
      lat++;
    end
    start = 1'b0;
    check("done_seen", W2'(seen), W2'(1'b1));
    check("latency",   W2'(lat), W2'(exp_lat));
    check("busy_cycles", W2'(busy_cnt), ez ? W2'(0) : W2'(N));
    check("busy_in_done", W2'(busy), W2'(1'b0));
    check("quot", W2'(quot), W2'(eq));
    check("rem",  W2'(rem),  W2'(er));
    check("dbz",  W2'(dbz),  W2'(ez));
    if (!ez) begin
      recon = W2'(quot) * W2'(tb_b) + W2'(rem);
      check("q*b+r", recon, W2'(ta));
      check("rem_lt_b", W2'(rem < tb_b), W2'(1'b1));
    end
  endtask

  task automatic run_ref(input logic [N-1:0] ta, input logic [N-1:0] tb_b);
    if (tb_b == '0) run_op(ta, tb_b, '1, ta, 1'b1, 1, 1'b0);
    else            run_op(ta, tb_b, ta / tb_b, ta % tb_b, 1'b0, int'(N), 1'b0);
  endtask

  function automatic logic [N-1:0] walk1(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [N-1:0] alt(input int ph);
    logic [N-1:0] v;
    for (int j = 0; j < int'(N); j++) v[j] = (((j + ph) % 2) == 0);
    return v;
  endfunction

  function automatic logic [N-1:0] rnd();
    return N'({$urandom(), $urandom(), $urandom()});
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] ones;
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    int           done_cnt;
    ones  = '1;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", W2'(busy), W2'(0));
    check("rst_done", W2'(done), W2'(0));
    check("rst_quot", W2'(quot), W2'(0));
    check("rst_rem",  W2'(rem),  W2'(0));
    check("rst_dbz",  W2'(dbz),  W2'(0));
    rst    = 1'b0;
    cmp_en = 1'b1;

    // Directed cases with hand-computed results.
    run_op(N'(100), N'(7), N'(14), N'(2), 1'b0, 65, 1'b0);
    @(negedge clk);
    run_op({1'b1, 64'h0}, N'(3), N'(64'h5555555555555555), N'(1), 1'b0, 65, 1'b0);
    @(negedge clk);
    run_op(N'(5), N'(9), N'(0), N'(5), 1'b0, 65, 1'b0);
    @(negedge clk);
    run_op(ones, N'(1), ones, N'(0), 1'b0, 65, 1'b0);
    @(negedge clk);
    run_op(ones, ones, N'(1), N'(0), 1'b0, 65, 1'b0);
    @(negedge clk);
    run_op(N'(123), N'(0), ones, N'(123), 1'b1, 1, 1'b0);
    run_op(N'(10), N'(3), N'(3), N'(1), 1'b0, 65, 1'b0);
    @(negedge clk);

    // start pulse with new operands mid-run is ignored; then a chained start.
    run_op(N'(100), N'(7), N'(14), N'(2), 1'b0, 65, 1'b1);
    run_op(N'(20), N'(6), N'(3), N'(2), 1'b0, 65, 1'b0);

    // Reset at E30 of an operation.
    @(negedge clk);
    a     = N'(100);
    b     = N'(7);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_busy", W2'(busy), W2'(0));
    check("arst_done", W2'(done), W2'(0));
    check("arst_quot", W2'(quot), W2'(0));
    check("arst_rem",  W2'(rem),  W2'(0));
    check("arst_dbz",  W2'(dbz),  W2'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    done_cnt = 0;
    repeat (80) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("no_done_after_rst", W2'(done_cnt), W2'(0));
    run_op(N'(100), N'(7), N'(14), N'(2), 1'b0, 65, 1'b0);
    @(negedge clk);

    // Walking-1s, walking-0s and alternating-bit sweeps.
    for (int i = 0; i < int'(N); i++) begin
      run_ref(~walk1(i), walk1((i * 5) % int'(N)));
      run_ref(walk1(i), alt(i) >> (i % 8));
      run_ref(alt(i), ~walk1((i * 3) % int'(N)));
    end
    @(negedge clk);

    // Random operands, magnitudes and gaps; occasional zero divisor.
    for (int k = 0; k < 60; k++) begin
      ra = rnd() >> $urandom_range(0, N - 1);
      rb = rnd() >> $urandom_range(0, N - 1);
      if ($urandom_range(0, 9) == 0) rb = '0;
      run_ref(ra, rb);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative restoring divider: the inverse of the team's shift-and-add `multiplier`. It computes an unsigned N-bit quotient and remainder over N clock cycles, one quotient bit per cycle. It sits beside the multiplier in the wide-arithmetic test suite. Its results are checked against the `/` and `%` operators and against the multiplier's `q*b + r == a` identity, with widths beyond 32 bits exercised.

## Interface
Parameters:
- `N`, default 65: operand, quotient and remainder width. Legal range is N ≥ 2.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  request a division; sampled only in IDLE.
- `a`  in  N  dividend, unsigned; captured when `start` is accepted.
- `b`  in  N  divisor, unsigned; captured when `start` is accepted.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when `quot`/`rem` are updated.
- `quot`  out  N  quotient, registered; holds until the next completion.
- `rem`  out  N  remainder, registered; holds until the next completion.
- `dbz`  out  1  divide-by-zero flag for the last completed operation; holds.

## Operation
- State machine has two states, IDLE and RUN.
- Reset values: state = IDLE; `busy`=0, `done`=0, `quot`=0, `rem`=0, `dbz`=0; internal registers = 0.
- IDLE with `start`=1 and `b`≠0:
  - Capture `a` into shift register `qa` (N bits).
  - Clear partial remainder `r` (N+1 bits).
  - Load `cnt`=N.
  - Go to RUN.
- IDLE with `start`=1 and `b`=0:
  - Stay in IDLE.
  - On the next edge: `quot` = all ones, `rem` = `a`, `dbz`=1, `done`=1.
- RUN, on each edge:
  - t = {r[N-1:0], qa[N-1]}.
  - If t ≥ `b` (unsigned, N+1-bit compare): r ← t − `b`; qa ← {qa[N-2:0], 1}.
  - Else: r ← t; qa ← {qa[N-2:0], 0}.
  - cnt ← cnt − 1.
- RUN, iteration with cnt=1:
  - Load `quot` ← final qa and `rem` ← final r[N-1:0].
  - Set `dbz`=0, `done`=1.
  - Go to IDLE.
- `start` is ignored while in RUN. Captured operands are not disturbed by changes on `a`/`b` during RUN.
- Arithmetic: r never exceeds N bits after a subtract. Bit N of r is only the carry-out of the shift, so the compare uses all N+1 bits.
- Results satisfy `quot*b + rem == a` and `rem < b` for every `b`≠0.

## Timing
- Edge E0 samples `start`.
- Iterations occur at edges E1..EN.
- `quot`, `rem` and `done` update at EN, so `done` is high for the cycle between EN and EN+1.
- Latency from start to result is N cycles; with N=65, `done` is seen 65 cycles after the start edge.
- `busy` is high from E0 to EN and low in the `done` cycle.
- A new `start` may be presented in the `done` cycle and is accepted at EN+1. Back-to-back throughput is one result per N+1 cycles.
- Divide by zero: result at E1 with `busy` never asserted.
- `done` is deasserted on the next edge unless a zero-divisor `start` was accepted at that same edge.
- `rst` asserted at any time, including mid-RUN: all outputs go to their reset values immediately, asynchronously. The in-flight operation is discarded and no `done` is produced.
- After `rst` deasserts, the first `start` is sampled on the next rising edge.

## Test plan
- N=65, a=100, b=7, start one cycle -> `done` at E65, `quot`=14, `rem`=2, `dbz`=0; `busy` high for exactly 65 cycles.
- a=2^64, b=3 -> `quot`=0x5555555555555555, `rem`=1; a=5, b=9 -> `quot`=0, `rem`=5.
- a=all ones, b=1 -> `quot`=all ones, `rem`=0; then a=all ones, b=all ones -> `quot`=1, `rem`=0.
- a=123, b=0 -> `done` at E1, `quot`=all ones, `rem`=123, `dbz`=1, `busy` stays 0. A following a=10, b=3 clears `dbz` and gives `quot`=3, `rem`=1.
- Operand changes and `start` pulses during RUN: pulse `start` with a=1, b=1 at E10 of a 100/7 operation -> it is ignored and the result is still 14 r 2. A `start` in the `done` cycle is accepted and its result appears 65 cycles later.
- Assert `rst` at E30 of an operation -> all outputs 0 at once and no `done` ever appears. A fresh start afterwards returns the correct result.
- Sweep with walking-1s, walking-0s and 101 patterns on a and b (b≠0) -> every result matches `/` and `%`, and `quot*b + rem == a`.
